marble_launcher: RTL and testbench

Sequencing controller for the marble board: holds the blue and red marble reservoirs, releases one marble at a time into the board's top-left (blue) or top-right (red) entry, and watches the bottom levers. The run halts when an interceptor catches a marble, a reservoir runs dry, or a marble never reaches a lever. It is the only block that drives marbles into the cell network of ramps, crossovers, bits and interceptors, and it turns that combinational/event-driven network into a clocked, one-marble-in-flight process.

---
 rtl/marble_pkg.sv | 16 +
 rtl/marble_launcher_flight_timer.sv | 27 ++
 rtl/marble_launcher.sv | 132 +++++++++++++
 tb/tb_marble_launcher.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/marble_pkg.sv
// Shared types and constants for the marble board launcher.
package marble_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RELEASE = 2'd1,
        FLIGHT  = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [1:0] DC_NONE      = 2'd0;
    localparam logic [1:0] DC_INTERCEPT = 2'd1;
    localparam logic [1:0] DC_EMPTY     = 2'd2;
    localparam logic [1:0] DC_TIMEOUT   = 2'd3;

endpackage

// File: rtl/marble_launcher_flight_timer.sv
// Counts idle FLIGHT cycles; expired flags the last allowed cycle of a flight.
module flight_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // Decoded from the registered count, so it is high only in the cycle the
    // count reaches TIMEOUT-1 while the flight is still idle.
    assign expired = enable && (count_reg == TW'(TIMEOUT - 1));

endmodule

// File: rtl/marble_launcher.sv
// Releases one marble at a time and watches the levers until the run halts.
module marble_launcher
    import marble_pkg::*;
#(
    parameter int BLUE_INIT = 8,
    parameter int RED_INIT  = 8,
    parameter int CNT_W     = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             first_red,
    input  logic             trig_left,
    input  logic             trig_right,
    input  logic             halted,
    output logic             o_blue,
    output logic             o_red,
    output logic [CNT_W-1:0] blue_left,
    output logic [CNT_W-1:0] red_left,
    output logic             busy,
    output logic             done,
    output logic [1:0]       done_code,
    output logic             err_double
);
    localparam logic [CNT_W-1:0] BLUE_FULL = CNT_W'(BLUE_INIT);
    localparam logic [CNT_W-1:0] RED_FULL  = CNT_W'(RED_INIT);

    state_t state_reg;
    logic   timer_clear;
    logic   timer_enable;
    logic   timer_expired;

    assign timer_clear  = (state_reg == RELEASE);
    assign timer_enable = (state_reg == FLIGHT) && !halted && !trig_left && !trig_right;

    flight_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            o_blue     <= 1'b0;
            o_red      <= 1'b0;
            blue_left  <= BLUE_FULL;
            red_left   <= RED_FULL;
            busy       <= 1'b0;
            done       <= 1'b0;
            done_code  <= DC_NONE;
            err_double <= 1'b0;
        end else begin
            o_blue <= 1'b0;
            o_red  <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        blue_left  <= BLUE_FULL;
                        red_left   <= RED_FULL;
                        done_code  <= DC_NONE;
                        err_double <= 1'b0;
                        if (first_red ? (RED_INIT == 0) : (BLUE_INIT == 0)) begin
                            state_reg <= DONE;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            done_code <= DC_EMPTY;
                        end else begin
                            state_reg <= RELEASE;
                            done      <= 1'b0;
                            busy      <= 1'b1;
                            if (first_red) begin
                                o_red    <= 1'b1;
                                red_left <= RED_FULL - 1'b1;
                            end else begin
                                o_blue    <= 1'b1;
                                blue_left <= BLUE_FULL - 1'b1;
                            end
                        end
                    end
                end
                RELEASE: begin
                    state_reg <= FLIGHT;
                end
                FLIGHT: begin
                    if (halted) begin
                        state_reg <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        done_code <= DC_INTERCEPT;
                    end else if (trig_left) begin
                        // A simultaneous right trigger is flagged but resolved as left.
                        if (trig_right) begin
                            err_double <= 1'b1;
                        end
                        if (blue_left != '0) begin
                            o_blue    <= 1'b1;
                            blue_left <= blue_left - 1'b1;
                            state_reg <= RELEASE;
                        end else begin
                            state_reg <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            done_code <= DC_EMPTY;
                        end
                    end else if (trig_right) begin
                        if (red_left != '0) begin
                            o_red     <= 1'b1;
                            red_left  <= red_left - 1'b1;
                            state_reg <= RELEASE;
                        end else begin
                            state_reg <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            done_code <= DC_EMPTY;
                        end
                    end else if (timer_expired) begin
                        state_reg <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        done_code <= DC_TIMEOUT;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_marble_launcher.sv
// Directed bench: one launcher with a small reservoir set, one with an empty red reservoir.
module tb_marble_launcher;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: BLUE_INIT=2, RED_INIT=1, TIMEOUT=6
    logic       rst, start, first_red, trig_left, trig_right, halted;
    logic       o_blue, o_red, busy, done, err_double;
    logic [3:0] blue_left, red_left;
    logic [1:0] done_code;

    // Instance B: BLUE_INIT=3, RED_INIT=0, TIMEOUT=4
    logic       b_rst, b_start, b_first_red, b_trig_left, b_trig_right, b_halted;
    logic       b_o_blue, b_o_red, b_busy, b_done, b_err_double;
    logic [3:0] b_blue_left, b_red_left;
    logic [1:0] b_done_code;

    int total = 0;
    int bad   = 0;

    marble_launcher #(.BLUE_INIT(2), .RED_INIT(1), .CNT_W(4), .TIMEOUT(6)) dut_a (
        .clk(clk), .rst(rst), .start(start), .first_red(first_red),
        .trig_left(trig_left), .trig_right(trig_right), .halted(halted),
        .o_blue(o_blue), .o_red(o_red), .blue_left(blue_left), .red_left(red_left),
        .busy(busy), .done(done), .done_code(done_code), .err_double(err_double)
    );

    marble_launcher #(.BLUE_INIT(3), .RED_INIT(0), .CNT_W(4), .TIMEOUT(4)) dut_b (
        .clk(clk), .rst(b_rst), .start(b_start), .first_red(b_first_red),
        .trig_left(b_trig_left), .trig_right(b_trig_right), .halted(b_halted),
        .o_blue(b_o_blue), .o_red(b_o_red), .blue_left(b_blue_left), .red_left(b_red_left),
        .busy(b_busy), .done(b_done), .done_code(b_done_code), .err_double(b_err_double)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) begin
            $display("check %s: got %0d", tag, obs);
        end else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Packs A's outputs: {o_blue,o_red,busy,done,err_double,done_code}
    function automatic logic [7:0] flags_a();
        return {1'b0, o_blue, o_red, busy, done, err_double, done_code};
    endfunction

    function automatic logic [7:0] flags_b();
        return {1'b0, b_o_blue, b_o_red, b_busy, b_done, b_err_double, b_done_code};
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; first_red = 1'b0;
        trig_left = 1'b0; trig_right = 1'b0; halted = 1'b0;
        b_rst = 1'b1; b_start = 1'b0; b_first_red = 1'b0;
        b_trig_left = 1'b0; b_trig_right = 1'b0; b_halted = 1'b0;
        tick();
        rst = 1'b0; b_rst = 1'b0;

        // Reset state
        chk("rst_flags", flags_a(), 8'b0000_0000);
        chk("rst_blue", 8'(blue_left), 8'd2);
        chk("rst_red", 8'(red_left), 8'd1);

        // Triggers ignored in IDLE
        trig_left = 1'b1; tick(); trig_left = 1'b0;
        chk("idle_trig", flags_a(), 8'b0000_0000);

        // Test 1: blue, red, blue, then empty
        start = 1'b1; tick(); start = 1'b0;
        chk("t1_rel0", flags_a(), 8'b0101_0000);
        chk("t1_blue0", 8'(blue_left), 8'd1);
        tick();
        chk("t1_flight", flags_a(), 8'b0001_0000);
        start = 1'b1; tick(); start = 1'b0;
        chk("t1_start_busy", flags_a(), 8'b0001_0000);
        trig_right = 1'b1; tick(); trig_right = 1'b0;
        chk("t1_red_pulse", flags_a(), 8'b0011_0000);
        chk("t1_red_cnt", 8'(red_left), 8'd0);
        tick();
        chk("t1_red_drop", flags_a(), 8'b0001_0000);
        trig_left = 1'b1; tick(); trig_left = 1'b0;
        chk("t1_blue_pulse", flags_a(), 8'b0101_0000);
        chk("t1_blue_cnt", 8'(blue_left), 8'd0);
        tick();
        trig_left = 1'b1; tick(); trig_left = 1'b0;
        chk("t1_empty", flags_a(), 8'b0000_1010);
        chk("t1_final_cnt", {blue_left, red_left}, 8'h00);
        tick();
        chk("t1_hold", flags_a(), 8'b0000_1010);

        // Test 2: halted beats trig_left
        start = 1'b1; tick(); start = 1'b0;
        chk("t2_reload", {blue_left, red_left}, 8'h11);
        tick();
        halted = 1'b1; trig_left = 1'b1; tick(); halted = 1'b0; trig_left = 1'b0;
        chk("t2_halt", flags_a(), 8'b0000_1001);
        chk("t2_blue", 8'(blue_left), 8'd1);

        // Test 4: double trigger resolves as left
        start = 1'b1; tick(); start = 1'b0;
        tick();
        trig_left = 1'b1; trig_right = 1'b1; tick(); trig_left = 1'b0; trig_right = 1'b0;
        chk("t4_double", flags_a(), 8'b0101_0100);
        chk("t4_cnt", {blue_left, red_left}, 8'h01);
        tick();
        halted = 1'b1; tick(); halted = 1'b0;
        chk("t4_sticky", flags_a(), 8'b0000_1101);

        // Test 6: rst during RELEASE
        start = 1'b1; tick(); start = 1'b0;
        chk("t6_rel", flags_a(), 8'b0101_0000);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t6_rst", flags_a(), 8'b0000_0000);
        chk("t6_cnt", {blue_left, red_left}, 8'h21);
        start = 1'b1; first_red = 1'b1; tick(); start = 1'b0; first_red = 1'b0;
        chk("t6_rerun", flags_a(), 8'b0011_0000);
        chk("t6_rerun_cnt", {blue_left, red_left}, 8'h20);

        // Test 3: timeout on instance B (TIMEOUT=4)
        b_start = 1'b1; tick(); b_start = 1'b0;
        chk("t3_rel", flags_b(), 8'b0101_0000);
        tick();
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("t3_fly%0d", i), flags_b(), 8'b0001_0000);
        end
        tick();
        chk("t3_timeout", flags_b(), 8'b0000_1011);

        // Test 5: empty red reservoir on start
        b_start = 1'b1; b_first_red = 1'b1; tick(); b_start = 1'b0; b_first_red = 1'b0;
        chk("t5_empty", flags_b(), 8'b0000_1010);
        chk("t5_cnt", {b_blue_left, b_red_left}, 8'h30);
        tick();
        chk("t5_hold", flags_b(), 8'b0000_1010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
